// File: rtl/rv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// rv_mem_arbiter
//   Shares one single-ported, non-pipelined memory bus between the uRV
//   instruction-fetch port (read-only) and the data load/store port. One
//   access is in flight at a time. Data wins arbitration, but after
//   MAX_D_STREAK back-to-back data grants with a fetch waiting, the fetch
//   goes next. An optional ack timeout converts a hung access into an error
//   completion (err_o pulse plus a normal completion with zero data).
//
// Ports
//   clk_i, rst_n_i        clock (rising edge), async active-low reset
//   im_*                  fetch side: address/request in, data/valid pulse out
//   dm_*                  data side: address/store data/lanes/write/load in,
//                         load data/valid pulse and store-busy out
//   mem_*                 shared bus: registered addr/data/sel/we/req out,
//                         ack and read data in
//   err_o                 1-cycle pulse when an access is aborted by timeout
// -----------------------------------------------------------------------------
module rv_mem_arbiter #(
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] im_addr_i,
    input  logic        im_rd_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_write_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_valid_l_o,
    output logic        dm_busy_s_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_sel_o,
    output logic        mem_we_o,
    output logic        mem_req_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_I_ACC = 2'd1;
    localparam logic [1:0] S_D_ACC = 2'd2;

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [1:0]    state_q,    state_d;
    logic [SW-1:0] streak_q,   streak_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_data_q, mem_data_d;
    logic [3:0]    mem_sel_q,  mem_sel_d;
    logic          mem_we_q,   mem_we_d;
    logic          mem_req_q,  mem_req_d;
    logic [31:0]   im_data_q,  im_data_d;
    logic          im_valid_q, im_valid_d;
    logic [31:0]   dm_data_q,  dm_data_d;
    logic          dm_valid_q, dm_valid_d;
    logic          st_done_q,  st_done_d;
    logic          err_q,      err_d;

    logic        d_req;
    logic        timeout_hit;
    logic [31:0] rdata;

    assign d_req = dm_load_i | dm_write_i;

    // Timer holds the number of ack-less access cycles already elapsed, so
    // the current cycle is the last allowed one when it equals LIMIT-1.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (int'(timer_q) == TIMEOUT_CYCLES - 1);

    // A timed-out access completes with zero data instead of bus data.
    assign rdata = mem_ack_i ? mem_data_i : 32'h0;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through the case statement can infer a latch.
        state_d    = state_q;
        streak_d   = streak_q;
        timer_d    = timer_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_sel_d  = mem_sel_q;
        mem_we_d   = mem_we_q;
        mem_req_d  = mem_req_q;
        im_data_d  = im_data_q;
        dm_data_d  = dm_data_q;
        im_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        st_done_d  = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (d_req && (!im_rd_i || streak_q < STREAK_MAX)) begin
                    state_d    = S_D_ACC;
                    mem_addr_d = dm_addr_i;
                    mem_data_d = dm_data_s_i;
                    mem_sel_d  = dm_data_select_i;
                    mem_we_d   = dm_write_i;  // write+load together is a store
                    mem_req_d  = 1'b1;
                    // The guard above keeps streak below the limit whenever a
                    // fetch is waiting, so the increment saturates at the limit.
                    streak_d   = im_rd_i ? streak_q + SW'(1) : '0;
                end else if (im_rd_i) begin
                    state_d    = S_I_ACC;
                    mem_addr_d = im_addr_i;
                    mem_data_d = 32'h0;
                    mem_sel_d  = 4'hF;
                    mem_we_d   = 1'b0;
                    mem_req_d  = 1'b1;
                    streak_d   = '0;
                end
            end

            S_I_ACC, S_D_ACC: begin
                // Ack has priority over a simultaneous timeout.
                if (mem_ack_i || timeout_hit) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    timer_d   = '0;
                    err_d     = !mem_ack_i;
                    if (state_q == S_I_ACC) begin
                        im_data_d  = rdata;
                        im_valid_d = 1'b1;
                    end else if (mem_we_q) begin
                        st_done_d  = 1'b1;
                    end else begin
                        dm_data_d  = rdata;
                        dm_valid_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            streak_q   <= '0;
            timer_q    <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_sel_q  <= '0;
            mem_we_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            im_data_q  <= '0;
            im_valid_q <= 1'b0;
            dm_data_q  <= '0;
            dm_valid_q <= 1'b0;
            st_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of its inputs regardless of statement order.
            state_q    <= state_d;
            streak_q   <= streak_d;
            timer_q    <= timer_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_sel_q  <= mem_sel_d;
            mem_we_q   <= mem_we_d;
            mem_req_q  <= mem_req_d;
            im_data_q  <= im_data_d;
            im_valid_q <= im_valid_d;
            dm_data_q  <= dm_data_d;
            dm_valid_q <= dm_valid_d;
            st_done_q  <= st_done_d;
            err_q      <= err_d;
        end
    end

    // Busy while a granted store is on the bus, and while a store request is
    // waiting; it drops in the store completion cycle even if dm_write_i is
    // still held, which is the CPU's cue to release the request.
    assign dm_busy_s_o = (state_q == S_D_ACC && mem_we_q) || (dm_write_i && !st_done_q);

    assign im_data_o    = im_data_q;
    assign im_valid_o   = im_valid_q;
    assign dm_data_l_o  = dm_data_q;
    assign dm_valid_l_o = dm_valid_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign mem_sel_o    = mem_sel_q;
    assign mem_we_o     = mem_we_q;
    assign mem_req_o    = mem_req_q;
    assign err_o        = err_q;

endmodule
